// File: rtl/leve_csr_pkg.sv
// leve_csr_pkg: shared types and helpers for the CSR request initiator.
//   csr_req_state_t : IDLE -> EXEC -> RESP sequencing of one CSR op
//   F3_*            : Zicsr funct3 codes
//   CSR_* commands  : CMD encodings toward the CSR file
//   MODE_*          : privilege level encodings
//   csr_is_ro()     : address lies in the read-only CSR space
//   csr_priv()      : lowest privilege level allowed to access the address
package leve_csr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } csr_req_state_t;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam logic [1:0] CSR_NONE  = 2'b00;
  localparam logic [1:0] CSR_SET   = 2'b01;
  localparam logic [1:0] CSR_CLEAR = 2'b10;
  localparam logic [1:0] CSR_WRITE = 2'b11;

  localparam logic [1:0] MODE_U = 2'b00;
  localparam logic [1:0] MODE_S = 2'b01;
  localparam logic [1:0] MODE_M = 2'b11;

  function automatic logic csr_is_ro(input logic [11:0] addr);
    return (addr[11:10] == 2'b11);
  endfunction

  function automatic logic [1:0] csr_priv(input logic [11:0] addr);
    return addr[9:8];
  endfunction

endpackage

// File: rtl/leve_csr_chk.sv
// leve_csr_chk: combinational legality check and command decode for one CSR op.
//   funct3  in  : Zicsr funct3
//   addr    in  : CSR address
//   rs1_idx in  : rs1 index or zimm
//   mode    in  : privilege level latched with the request
//   cmd     out : command to drive to the CSR file (CSR_NONE when suppressed/illegal)
//   illegal out : op must trap as an illegal instruction
//   wr_en   out : op carries write intent (RW/RWI always, set/clear only with rs1/zimm != 0)
// Optional feature: CSR_PRIV_CHECK_EN adds a privilege trap (addr[9:8] > mode).
module leve_csr_chk
  import leve_csr_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [11:0] addr,
  input  logic [4:0]  rs1_idx,
  input  logic [1:0]  mode,
  output logic [1:0]  cmd,
  output logic        illegal,
  output logic        wr_en
);

  logic [1:0] op_cmd_s;
  logic       bad_f3_s;
  logic       priv_fault_s;

`ifdef CSR_PRIV_CHECK_EN
  assign priv_fault_s = (csr_priv(addr) > mode);
`else
  logic unused_mode_s;
  assign unused_mode_s = ^mode;
  assign priv_fault_s  = 1'b0;
`endif

  // Decode funct3 into a command and write intent, then apply the traps.
  always_comb begin
    op_cmd_s = CSR_NONE;
    bad_f3_s = 1'b0;
    wr_en    = 1'b0;
    case (funct3)
      F3_RW, F3_RWI: begin
        op_cmd_s = CSR_WRITE;
        wr_en    = 1'b1;
      end
      F3_RS, F3_RSI: begin
        op_cmd_s = CSR_SET;
        wr_en    = (rs1_idx != 5'd0);
      end
      F3_RC, F3_RCI: begin
        op_cmd_s = CSR_CLEAR;
        wr_en    = (rs1_idx != 5'd0);
      end
      default: begin
        bad_f3_s = 1'b1;
      end
    endcase

    illegal = bad_f3_s | (wr_en & csr_is_ro(addr)) | priv_fault_s;

    // Set/clear with a zero operand is still a legal read, but must not write.
    if (illegal || !wr_en) begin
      cmd = CSR_NONE;
    end else begin
      cmd = op_cmd_s;
    end
  end

endmodule

// File: rtl/leve_csr_req.sv
// leve_csr_req: initiator side of the CMD/CSR/CSR_WD/CSR_RD CSR-file port.
// Accepts one decoded Zicsr op, checks legality, drives a single command in EXEC,
// captures the pre-write value and hands it to writeback; RETIRE pulses on the
// handshake of a legal response.
//   CLK, RSTn                     : clock, synchronous active-low reset
//   REQ_VALID/READY/FUNCT3/CSR/RS1_IDX/RS1_DATA/RD_IDX, MODE : request from issue
//   CMD, CSR, CSR_WD, CSR_RD      : CSR-file port (CSR_RD is combinational, pre-write)
//   RSP_VALID/READY/RD_IDX/DATA/ILLEGAL : response to writeback
//   RETIRE                        : completion pulse for legal ops
// Optional feature: define CSR_PRIV_CHECK_EN to trap accesses above the latched MODE.
// XLEN defaults to 32.
module leve_csr_req
  import leve_csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            REQ_VALID,
  output logic            REQ_READY,
  input  logic [2:0]      REQ_FUNCT3,
  input  logic [11:0]     REQ_CSR,
  input  logic [4:0]      REQ_RS1_IDX,
  input  logic [XLEN-1:0] REQ_RS1_DATA,
  input  logic [4:0]      REQ_RD_IDX,
  input  logic [1:0]      MODE,
  output logic [1:0]      CMD,
  output logic [11:0]     CSR,
  output logic [XLEN-1:0] CSR_WD,
  input  logic [XLEN-1:0] CSR_RD,
  output logic            RSP_VALID,
  input  logic            RSP_READY,
  output logic [4:0]      RSP_RD_IDX,
  output logic [XLEN-1:0] RSP_DATA,
  output logic            RSP_ILLEGAL,
  output logic            RETIRE
);

  csr_req_state_t  state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [11:0]     csr_q, csr_d;
  logic [4:0]      rs1_idx_q, rs1_idx_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [4:0]      rd_idx_q, rd_idx_d;
  logic [1:0]      mode_q, mode_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_illegal_q, rsp_illegal_d;

  logic [1:0]      chk_cmd_s;
  logic            chk_illegal_s;
  logic            chk_wr_en_s;

  leve_csr_chk u_chk (
    .funct3  (funct3_q),
    .addr    (csr_q),
    .rs1_idx (rs1_idx_q),
    .mode    (mode_q),
    .cmd     (chk_cmd_s),
    .illegal (chk_illegal_s),
    .wr_en   (chk_wr_en_s)
  );

  logic unused_wr_en_s;
  assign unused_wr_en_s = chk_wr_en_s;

  // Next-state and capture logic for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_d       = state_q;
    funct3_d      = funct3_q;
    csr_d         = csr_q;
    rs1_idx_d     = rs1_idx_q;
    rs1_data_d    = rs1_data_q;
    rd_idx_d      = rd_idx_q;
    mode_d        = mode_q;
    rsp_data_d    = rsp_data_q;
    rsp_illegal_d = rsp_illegal_q;
    case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          funct3_d   = REQ_FUNCT3;
          csr_d      = REQ_CSR;
          rs1_idx_d  = REQ_RS1_IDX;
          rs1_data_d = REQ_RS1_DATA;
          rd_idx_d   = REQ_RD_IDX;
          mode_d     = MODE;
          state_d    = EXEC;
        end else begin
          state_d    = IDLE;
        end
      end
      EXEC: begin
        // CSR_RD is the pre-write value; the CSR file commits on this same edge.
        if (chk_illegal_s) begin
          rsp_data_d = '0;
        end else begin
          rsp_data_d = CSR_RD;
        end
        rsp_illegal_d = chk_illegal_s;
        state_d       = RESP;
      end
      RESP: begin
        if (RSP_READY) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q       <= IDLE;
      funct3_q      <= 3'd0;
      csr_q         <= 12'd0;
      rs1_idx_q     <= 5'd0;
      rs1_data_q    <= '0;
      rd_idx_q      <= 5'd0;
      mode_q        <= 2'd0;
      rsp_data_q    <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      funct3_q      <= funct3_d;
      csr_q         <= csr_d;
      rs1_idx_q     <= rs1_idx_d;
      rs1_data_q    <= rs1_data_d;
      rd_idx_q      <= rd_idx_d;
      mode_q        <= mode_d;
      rsp_data_q    <= rsp_data_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  // CSR-file port and handshake outputs decoded from registered state.
  always_comb begin
    // Reset masks CMD so an EXEC cut short by reset never reaches the CSR file.
    if ((state_q == EXEC) && RSTn) begin
      CMD = chk_cmd_s;
    end else begin
      CMD = CSR_NONE;
    end
    // funct3[2] selects the zero-extended immediate forms.
    if (funct3_q[2]) begin
      CSR_WD = {{(XLEN-5){1'b0}}, rs1_idx_q};
    end else begin
      CSR_WD = rs1_data_q;
    end
    CSR         = csr_q;
    REQ_READY   = (state_q == IDLE);
    RSP_VALID   = (state_q == RESP);
    RSP_RD_IDX  = rd_idx_q;
    RSP_DATA    = rsp_data_q;
    RSP_ILLEGAL = rsp_illegal_q;
    RETIRE      = (state_q == RESP) && RSP_READY && !rsp_illegal_q;
  end

endmodule

// File: tb/tb_leve_csr_req.sv
// Self-checking bench for leve_csr_req with a small behavioural CSR file.
module tb_leve_csr_req;
  import leve_csr_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr;
  logic [4:0]  req_rs1_idx;
  logic [31:0] req_rs1_data;
  logic [4:0]  req_rd_idx;
  logic [1:0]  mode;
  logic [1:0]  cmd;
  logic [11:0] csr;
  logic [31:0] csr_wd, csr_rd;
  logic        rsp_valid, rsp_ready;
  logic [4:0]  rsp_rd_idx;
  logic [31:0] rsp_data;
  logic        rsp_illegal, retire;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  leve_csr_req #(.XLEN(32)) dut (
    .CLK(clk), .RSTn(rstn),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_FUNCT3(req_funct3),
    .REQ_CSR(req_csr), .REQ_RS1_IDX(req_rs1_idx), .REQ_RS1_DATA(req_rs1_data),
    .REQ_RD_IDX(req_rd_idx), .MODE(mode),
    .CMD(cmd), .CSR(csr), .CSR_WD(csr_wd), .CSR_RD(csr_rd),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RD_IDX(rsp_rd_idx),
    .RSP_DATA(rsp_data), .RSP_ILLEGAL(rsp_illegal), .RETIRE(retire)
  );

  // Behavioural CSR file: mtvec, mtval, mscratch, mstatus, fflags, cycle, mhartid.
  logic [31:0] mtvec_m = 32'h0, mtval_m = 32'h0, mscratch_m = 32'h0, mstatus_m = 32'h0;
  logic [31:0] cycle_m = 32'h0;
  logic [4:0]  fflags_m = 5'h0;

  function automatic logic [31:0] apply(input logic [31:0] old, input logic [1:0] c,
                                        input logic [31:0] wd);
    case (c)
      CSR_WRITE: return wd;
      CSR_SET:   return old | wd;
      CSR_CLEAR: return old & ~wd;
      default:   return old;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h305: return mtvec_m;
      12'h343: return mtval_m;
      12'h340: return mscratch_m;
      12'h300: return mstatus_m;
      12'h001: return {27'd0, fflags_m};
      12'hC00: return cycle_m;
      12'hF14: return 32'h0000_0007;
      default: return 32'h0;
    endcase
  endfunction

  always_comb csr_rd = model_read(csr);

  always @(posedge clk) begin
    logic [31:0] nv;
    cycle_m <= cycle_m + 32'd1;
    nv = apply(model_read(csr), cmd, csr_wd);
    if (cmd != CSR_NONE) begin
      case (csr)
        12'h305: mtvec_m    <= nv;
        12'h343: mtval_m    <= nv;
        12'h340: mscratch_m <= nv;
        12'h300: mstatus_m  <= nv;
        12'h001: fflags_m   <= nv[4:0];
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [4:0]  idx;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [1:0]  md;
    logic [1:0]  ecmd;
    logic        chk_wd;
    logic [31:0] ewd;
    logic        use_cyc;
    logic [31:0] ersp;
    logic        eill;
    logic        chk_after;
    logic [31:0] eafter;
  } vec_t;

  vec_t vecs[15];

  task automatic do_op(input vec_t v, input int n);
    logic [31:0] exp_rsp;
    @(negedge clk);
    chk($sformatf("v%0d req_ready_idle", n), {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_funct3 = v.f3; req_csr = v.addr; req_rs1_idx = v.idx;
    req_rs1_data = v.data; req_rd_idx = v.rd; mode = v.md; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk($sformatf("v%0d exec_cmd", n), {30'd0, cmd}, {30'd0, v.ecmd});
    chk($sformatf("v%0d exec_csr", n), {20'd0, csr}, {20'd0, v.addr});
    if (v.chk_wd) chk($sformatf("v%0d exec_wd", n), csr_wd, v.ewd);
    chk($sformatf("v%0d exec_req_ready", n), {31'd0, req_ready}, 32'd0);
    exp_rsp = v.use_cyc ? cycle_m : v.ersp;
    @(negedge clk);
    chk($sformatf("v%0d rsp_valid", n), {31'd0, rsp_valid}, 32'd1);
    chk($sformatf("v%0d rsp_data", n), rsp_data, exp_rsp);
    chk($sformatf("v%0d rsp_illegal", n), {31'd0, rsp_illegal}, {31'd0, v.eill});
    chk($sformatf("v%0d rsp_rd_idx", n), {27'd0, rsp_rd_idx}, {27'd0, v.rd});
    chk($sformatf("v%0d resp_cmd_none", n), {30'd0, cmd}, 32'd0);
    chk($sformatf("v%0d retire_wait", n), {31'd0, retire}, 32'd0);
    rsp_ready = 1'b1;
    #1;
    chk($sformatf("v%0d retire_hs", n), {31'd0, retire}, {31'd0, ~v.eill});
    @(negedge clk);
    rsp_ready = 1'b0;
    chk($sformatf("v%0d rsp_valid_after", n), {31'd0, rsp_valid}, 32'd0);
    chk($sformatf("v%0d retire_after", n), {31'd0, retire}, 32'd0);
    if (v.chk_after) chk($sformatf("v%0d csr_after", n), model_read(v.addr), v.eafter);
  endtask

  initial begin
    logic [31:0] held;
    //            f3      addr     idx    data          rd     md      ecmd       cwd  ewd           cyc  ersp          ill  ca   after
    vecs[0]  = '{F3_RW,  12'h305, 5'd1,  32'h8000_0000, 5'd5,  MODE_M, CSR_WRITE, 1'b1, 32'h8000_0000, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0000};
    vecs[1]  = '{F3_RS,  12'h305, 5'd2,  32'h0,         5'd6,  MODE_M, CSR_SET,   1'b1, 32'h0,         1'b0, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000};
    vecs[2]  = '{F3_RS,  12'hC00, 5'd0,  32'h1234,      5'd10, MODE_M, CSR_NONE,  1'b1, 32'h1234,      1'b1, 32'h0,         1'b0, 1'b0, 32'h0};
    vecs[3]  = '{F3_RW,  12'hC00, 5'd5,  32'h5,         5'd7,  MODE_M, CSR_NONE,  1'b1, 32'h5,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[4]  = '{F3_RWI, 12'h001, 5'h1F, 32'hFFFF_FFFF, 5'd1,  MODE_M, CSR_WRITE, 1'b1, 32'h1F,        1'b0, 32'h0,         1'b0, 1'b1, 32'h1F};
    vecs[5]  = '{F3_RCI, 12'h001, 5'h03, 32'hFFFF_FFFF, 5'd2,  MODE_M, CSR_CLEAR, 1'b1, 32'h3,         1'b0, 32'h1F,        1'b0, 1'b1, 32'h1C};
    vecs[6]  = '{F3_RSI, 12'h340, 5'h0A, 32'h0,         5'd3,  MODE_M, CSR_SET,   1'b1, 32'hA,         1'b0, 32'h0,         1'b0, 1'b1, 32'hA};
    vecs[7]  = '{F3_RC,  12'h340, 5'd4,  32'h2,         5'd4,  MODE_M, CSR_CLEAR, 1'b1, 32'h2,         1'b0, 32'hA,         1'b0, 1'b1, 32'h8};
    vecs[8]  = '{3'b000, 12'h340, 5'd1,  32'hFF,        5'd8,  MODE_M, CSR_NONE,  1'b1, 32'hFF,        1'b0, 32'h0,         1'b1, 1'b1, 32'h8};
    vecs[9]  = '{3'b100, 12'h340, 5'd9,  32'h55,        5'd9,  MODE_M, CSR_NONE,  1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h8};
    vecs[10] = '{F3_RSI, 12'h340, 5'd0,  32'hFFFF,      5'd11, MODE_M, CSR_NONE,  1'b0, 32'h0,         1'b0, 32'h8,         1'b0, 1'b1, 32'h8};
    vecs[11] = '{F3_RCI, 12'hF14, 5'd0,  32'h0,         5'd12, MODE_M, CSR_NONE,  1'b0, 32'h0,         1'b0, 32'h7,         1'b0, 1'b0, 32'h0};
    vecs[12] = '{F3_RS,  12'hF14, 5'd1,  32'h1,         5'd13, MODE_M, CSR_NONE,  1'b1, 32'h1,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[13] = '{F3_RW,  12'h340, 5'd0,  32'h0,         5'd14, MODE_M, CSR_WRITE, 1'b1, 32'h0,         1'b0, 32'h8,         1'b0, 1'b1, 32'h0};
`ifdef CSR_PRIV_CHECK_EN
    vecs[14] = '{F3_RS,  12'h300, 5'd1,  32'h8,         5'd15, MODE_U, CSR_NONE,  1'b1, 32'h8,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0};
`else
    vecs[14] = '{F3_RS,  12'h300, 5'd1,  32'h8,         5'd15, MODE_U, CSR_SET,   1'b1, 32'h8,         1'b0, 32'h0,         1'b0, 1'b1, 32'h8};
`endif

    rstn = 1'b0; req_valid = 1'b0; req_funct3 = 3'd0; req_csr = 12'd0; req_rs1_idx = 5'd0;
    req_rs1_data = 32'd0; req_rd_idx = 5'd0; mode = MODE_M; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_illegal", {31'd0, rsp_illegal}, 32'd0);
    chk("rst_rsp_rd_idx", {27'd0, rsp_rd_idx}, 32'd0);
    chk("rst_retire", {31'd0, retire}, 32'd0);
    chk("rst_cmd", {30'd0, cmd}, 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 15; i++) do_op(vecs[i], i);

    // Response back-pressure: outputs hold, no new request accepted, no early RETIRE.
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = F3_RS; req_csr = 12'h305; req_rs1_idx = 5'd0;
    req_rs1_data = 32'h0; req_rd_idx = 5'd9; mode = MODE_M;
    @(negedge clk);
    req_funct3 = F3_RW; req_csr = 12'h340; req_rs1_idx = 5'd3; req_rs1_data = 32'hDEAD; req_rd_idx = 5'd20;
    chk("stall_exec_cmd", {30'd0, cmd}, 32'd0);
    @(negedge clk);
    held = rsp_data;
    chk("stall_rsp_data0", held, 32'h8000_0000);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_valid", k), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("stall%0d_data", k), rsp_data, 32'h8000_0000);
      chk($sformatf("stall%0d_rd_idx", k), {27'd0, rsp_rd_idx}, 32'd9);
      chk($sformatf("stall%0d_req_ready", k), {31'd0, req_ready}, 32'd0);
      chk($sformatf("stall%0d_retire", k), {31'd0, retire}, 32'd0);
      chk($sformatf("stall%0d_cmd", k), {30'd0, cmd}, 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("stall_retire_hs", {31'd0, retire}, 32'd1);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("stall_retire_after", {31'd0, retire}, 32'd0);
    chk("stall_idle_ready", {31'd0, req_ready}, 32'd1);
    chk("stall_mscratch_untouched", mscratch_m, 32'h0);

    // Reset arriving during EXEC must abort the write.
    req_valid = 1'b1; req_funct3 = F3_RW; req_csr = 12'h343; req_rs1_idx = 5'd7;
    req_rs1_data = 32'hCAFE_F00D; req_rd_idx = 5'd21;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_exec_cmd_pre", {30'd0, cmd}, {30'd0, CSR_WRITE});
    rstn = 1'b0;
    #1;
    chk("abort_cmd_masked", {30'd0, cmd}, 32'd0);
    @(negedge clk);
    chk("abort_mtval", mtval_m, 32'h0);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_rsp_rd_idx", {27'd0, rsp_rd_idx}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("abort_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_idle_mtval", mtval_m, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
